// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcodes, NOP encoding, fetch FSM states and fetch defaults
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} fetch_state_e;
endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry {instr, pc} holding register for fetch returns that arrive while decode stalls
module if_skid_buffer
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [31:0]       wr_instr,
    input  logic [ADDR_W-1:0] wr_pc,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);
    // capture a returned word on load; drain or flush frees the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            instr <= INSTR_NOP;
            pc <= '0;
        end else begin
            full <= load | (full & ~drain & ~flush);
            if (load) begin
                instr <= wr_instr;
                pc <= wr_pc;
            end
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and single-outstanding imem fetcher feeding the decode stage
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4
);
    fetch_state_e state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, tgt, tgt_nx, redir_pc, buf_pc;
    logic [31:0] buf_instr;
    logic slot_free, load_out, load_buf, drain_buf, flush_buf, buf_full;

    assign redir_pc = redirect_target & ~ADDR_W'(3);
    assign slot_free = !if_valid || !id_stall;
    assign imem_addr = pc;
    assign if_pc_plus4 = if_pc + ADDR_W'(4);

    if_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
        .clk(clk),
        .rst_n(rst_n),
        .load(load_buf),
        .drain(drain_buf),
        .flush(flush_buf),
        .wr_instr(imem_rdata),
        .wr_pc(pc),
        .full(buf_full),
        .instr(buf_instr),
        .pc(buf_pc)
    );

    // state, PC and latched DRAIN target registers; reset aborts any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= RESET_PC;
            tgt <= RESET_PC;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            tgt <= tgt_nx;
        end
    end

    // next-state, PC update and datapath steering; the request address only moves after an ack
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        tgt_nx = tgt;
        imem_req = 1'b0;
        load_out = 1'b0;
        load_buf = 1'b0;
        drain_buf = 1'b0;
        flush_buf = 1'b0;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                pc_nx = redirect ? redir_pc : pc;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack && redirect) begin
                    pc_nx = redir_pc;
                end else if (imem_ack) begin
                    load_out = slot_free;
                    load_buf = !slot_free;
                    pc_nx = pc + ADDR_W'(4);
                    state_nx = slot_free ? FETCH : WAIT;
                end else if (redirect) begin
                    tgt_nx = redir_pc;
                    state_nx = DRAIN;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush_buf = 1'b1;
                    pc_nx = redir_pc;
                    state_nx = FETCH;
                end else if (!id_stall && buf_full) begin
                    drain_buf = 1'b1;
                    state_nx = FETCH;
                end
            end
            default: begin
                imem_req = 1'b1;
                tgt_nx = redirect ? redir_pc : tgt;
                if (imem_ack) begin
                    pc_nx = redirect ? redir_pc : tgt;
                    state_nx = FETCH;
                end
            end
        endcase
    end

    // decode-facing output register: redirect flushes first, stall holds, otherwise consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= INSTR_NOP;
            if_pc <= RESET_PC;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (load_out) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc <= pc;
        end else if (drain_buf) begin
            if_valid <= 1'b1;
            if_instr <= buf_instr;
            if_pc <= buf_pc;
        end else if (!id_stall) begin
            if_valid <= 1'b0;
        end
    end
endmodule
